sram_like_fetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the sram-like CPU. Replaces the single-outstanding fetch path: it issues sequential fetches on the sram-like instruction port with up to DEPTH requests in flight, stores returned instructions in order, and presents them to decode through a valid/ready handshake. A redirect (branch, exception, eret) flushes stored entries and silently discards responses still in flight.

---
 rtl/sram_like_pkg.sv | 15 +
 rtl/sram_like_fetch_buf.sv | 65 ++++++
 rtl/sram_like_fetch_queue.sv | 115 +++++++++++
 tb/tb_sram_like_fetch_queue.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/sram_like_pkg.sv
// Shared definitions for the sram-like bus masters: bus encodings and
// default widths / reset vector of the CPU front end.
package sram_like_pkg;

  localparam logic [1:0]  SRAM_SIZE_WORD = 2'b10;
  localparam int          ADDR_W_DEF     = 32;
  localparam int          DATA_W_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF   = 32'hBFC0_0000;

  // Width of a counter that must hold every value in 0..depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sram_like_fetch_buf.sv
// In-order ring of fetch entries: pc is written on allocation, the
// instruction on fill, and the head is presented once it has been filled.
module sram_like_fetch_buf
  import sram_like_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              alloc,
  input  logic [ADDR_W-1:0] alloc_pc,
  input  logic              fill,
  input  logic [DATA_W-1:0] fill_inst,
  input  logic              pop,
  input  logic              flush,
  output logic              head_valid,
  output logic [ADDR_W-1:0] head_pc,
  output logic [DATA_W-1:0] head_inst
);

  localparam int PW = $clog2(DEPTH);

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] inst_mem [DEPTH];
  logic [DEPTH-1:0]  filled;
  logic [PW-1:0]     head_ptr, alloc_ptr, fill_ptr;

  // Fill and pop never address the same slot: fill targets the oldest
  // unfilled entry, pop the head which must already be filled.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      filled    <= '0;
      head_ptr  <= '0;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
    end else if (flush) begin
      filled    <= '0;
      head_ptr  <= '0;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
    end else begin
      if (alloc) alloc_ptr <= alloc_ptr + 1'b1;
      if (fill) begin
        filled[fill_ptr] <= 1'b1;
        fill_ptr         <= fill_ptr + 1'b1;
      end
      if (pop) begin
        filled[head_ptr] <= 1'b0;
        head_ptr         <= head_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (alloc) pc_mem[alloc_ptr]  <= alloc_pc;
    if (fill)  inst_mem[fill_ptr] <= fill_inst;
  end

  assign head_valid = filled[head_ptr];
  assign head_pc    = pc_mem[head_ptr];
  assign head_inst  = inst_mem[head_ptr];

endmodule

// File: rtl/sram_like_fetch_queue.sv
// Multi-outstanding sequential instruction fetch on the sram-like port, with
// in-order buffering toward decode and redirect flush of stale responses.
module sram_like_fetch_queue
  import sram_like_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_inst,
  output logic              inst_req,
  output logic              inst_wr,
  output logic [1:0]        inst_size,
  output logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_wdata,
  input  logic [DATA_W-1:0] inst_rdata,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok
);

  localparam int            CW      = cnt_width(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_n, issue_addr_q, issue_addr_n;
  logic              req_q, req_n, stale_q, stale_n, hold;
  logic [CW-1:0]     reserved_q, reserved_n, pending_q, pending_n, discard_q, discard_n;
  logic              acc, acc_cur, acc_stale, drop, fill, pop;

  // pending counts current-stream requests accepted but not yet returned;
  // on redirect exactly those turn into responses that must be discarded.
  assign acc       = req_q & inst_addr_ok;
  assign acc_cur   = acc & ~stale_q & ~redirect_valid;
  assign acc_stale = acc & ~acc_cur;
  assign drop      = inst_data_ok & (discard_q != '0);
  assign fill      = inst_data_ok & (discard_q == '0) & (pending_q != '0);
  assign pop       = out_valid & out_ready;
  assign hold      = req_q & ~inst_addr_ok;

  always_comb begin
    fetch_pc_n = fetch_pc_q;
    discard_n  = discard_q + CW'(acc_stale) - CW'(drop);
    reserved_n = reserved_q + CW'(acc_cur) - CW'(pop);
    pending_n  = pending_q + CW'(acc_cur) - CW'(fill);
    if (redirect_valid) begin
      fetch_pc_n = redirect_pc;
      discard_n  = discard_n + pending_q - CW'(fill);
      reserved_n = '0;
      pending_n  = '0;
    end else if (acc_cur) begin
      fetch_pc_n = fetch_pc_q + ADDR_W'(4);
    end
    // An unaccepted request is never withdrawn, even across a redirect.
    req_n        = hold | ((reserved_n + discard_n) < DEPTH_C);
    stale_n      = hold & (stale_q | redirect_valid);
    issue_addr_n = hold ? issue_addr_q : fetch_pc_n;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc_q   <= RESET_PC;
      issue_addr_q <= RESET_PC;
      req_q        <= 1'b0;
      stale_q      <= 1'b0;
      reserved_q   <= '0;
      pending_q    <= '0;
      discard_q    <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_n;
      issue_addr_q <= issue_addr_n;
      req_q        <= req_n;
      stale_q      <= stale_n;
      reserved_q   <= reserved_n;
      pending_q    <= pending_n;
      discard_q    <= discard_n;
    end
  end

  sram_like_fetch_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_buf (
    .clk        (clk),
    .resetn     (resetn),
    .alloc      (acc_cur),
    .alloc_pc   (issue_addr_q),
    .fill       (fill & ~redirect_valid),
    .fill_inst  (inst_rdata),
    .pop        (pop),
    .flush      (redirect_valid),
    .head_valid (out_valid),
    .head_pc    (out_pc),
    .head_inst  (out_inst)
  );

  assign inst_req   = req_q;
  assign inst_addr  = issue_addr_q;
  assign inst_wr    = 1'b0;
  assign inst_size  = SRAM_SIZE_WORD;
  assign inst_wdata = '0;

`ifndef SYNTHESIS
  a_data_ok_expected: assert property (@(posedge clk) disable iff (!resetn)
    inst_data_ok |-> ((discard_q != '0) || (pending_q != '0)));
`endif

endmodule

// File: tb/tb_sram_like_fetch_queue.sv
// Directed bench for sram_like_fetch_queue with a simple in-order memory
// answering one cycle after each accepted request.
module tb_sram_like_fetch_queue;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_pc, out_inst;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic [31:0] inst_rdata = '0;
  logic        inst_addr_ok = 1'b0, inst_data_ok = 1'b0;

  int total = 0;
  int bad = 0;
  bit mem_addr_ok = 1'b0;
  bit mem_resp_en = 1'b1;
  logic [31:0] rq[$], acc_log[$], pop_pc[$], pop_inst[$];

  localparam logic [31:0] BASE = 32'hBFC0_0000;
  localparam logic [31:0] RDIR = 32'h8000_1000;

  sram_like_fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'hBFC0_0000)) dut (
    .clk(clk), .resetn(resetn), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // Called at a falling edge: drives the bus for the next rising edge and
  // logs the handshakes that edge will complete.
  task automatic cycle();
    if (mem_resp_en && rq.size() > 0) begin
      inst_data_ok = 1'b1;
      inst_rdata   = memf(rq.pop_front());
    end else begin
      inst_data_ok = 1'b0;
      inst_rdata   = '0;
    end
    inst_addr_ok = mem_addr_ok;
    if (inst_req && inst_addr_ok) begin
      rq.push_back(inst_addr);
      acc_log.push_back(inst_addr);
    end
    if (out_valid && out_ready) begin
      pop_pc.push_back(out_pc);
      pop_inst.push_back(out_inst);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    resetn = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
    mem_addr_ok = 1'b0; mem_resp_en = 1'b1;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
    rq.delete(); acc_log.delete(); pop_pc.delete(); pop_inst.delete();
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (inst_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", inst_req); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    total++; if (inst_addr !== BASE) begin bad++; $display("FAIL reset_addr: got %h want %h", inst_addr, BASE); end
    total++; if (inst_size !== 2'b10) begin bad++; $display("FAIL size: got %b want 10", inst_size); end
    total++; if (inst_wr !== 1'b0 || inst_wdata !== 32'h0) begin bad++; $display("FAIL wr_const: got %b/%h want 0/0", inst_wr, inst_wdata); end
    cycle();
    total++; if (inst_req !== 1'b1 || inst_addr !== BASE) begin bad++; $display("FAIL first_req: got %b@%h want 1@%h", inst_req, inst_addr, BASE); end
  endtask

  task automatic test_stream();
    do_reset();
    mem_addr_ok = 1'b1; out_ready = 1'b1;
    repeat (12) cycle();
    total++; if (pop_pc.size() != 9) begin bad++; $display("FAIL stream_count: got %0d want 9", pop_pc.size()); end
    for (int i = 0; i < 6; i++) begin
      logic [31:0] e;
      e = BASE + 32'(4 * i);
      total++; if (acc_log[i] !== e) begin bad++; $display("FAIL stream_addr%0d: got %h want %h", i, acc_log[i], e); end
      total++; if (pop_pc[i] !== e) begin bad++; $display("FAIL stream_pc%0d: got %h want %h", i, pop_pc[i], e); end
      total++; if (pop_inst[i] !== memf(e)) begin bad++; $display("FAIL stream_inst%0d: got %h want %h", i, pop_inst[i], memf(e)); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mem_addr_ok = 1'b1; out_ready = 1'b0;
    repeat (10) cycle();
    total++; if (acc_log.size() != 4) begin bad++; $display("FAIL bp_accepted: got %0d want 4", acc_log.size()); end
    total++; if (inst_req !== 1'b0) begin bad++; $display("FAIL bp_req_low: got %b want 0", inst_req); end
    total++; if (out_valid !== 1'b1 || out_pc !== BASE) begin bad++; $display("FAIL bp_head: got %b@%h want 1@%h", out_valid, out_pc, BASE); end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    repeat (6) cycle();
    total++; if (acc_log.size() != 5) begin bad++; $display("FAIL bp_one_more: got %0d want 5", acc_log.size()); end
    total++; if (acc_log[4] !== BASE + 32'h10) begin bad++; $display("FAIL bp_next_addr: got %h want %h", acc_log[4], BASE + 32'h10); end
    total++; if (pop_pc.size() != 1) begin bad++; $display("FAIL bp_pops: got %0d want 1", pop_pc.size()); end
    total++; if (inst_req !== 1'b0) begin bad++; $display("FAIL bp_req_low2: got %b want 0", inst_req); end
  endtask

  task automatic test_addr_ok_delay();
    do_reset();
    out_ready = 1'b0; mem_addr_ok = 1'b0;
    cycle();
    for (int k = 0; k < 3; k++) begin
      total++; if (inst_req !== 1'b1 || inst_addr !== BASE) begin bad++; $display("FAIL delay_hold%0d: got %b@%h want 1@%h", k, inst_req, inst_addr, BASE); end
      cycle();
    end
    mem_addr_ok = 1'b1;
    cycle();
    mem_addr_ok = 1'b0;
    total++; if (acc_log.size() != 1) begin bad++; $display("FAIL delay_accepts: got %0d want 1", acc_log.size()); end
    total++; if (inst_req !== 1'b1 || inst_addr !== BASE + 32'h4) begin bad++; $display("FAIL delay_next: got %b@%h want 1@%h", inst_req, inst_addr, BASE + 32'h4); end
    cycle();
    total++; if (inst_addr !== BASE + 32'h4) begin bad++; $display("FAIL delay_once: got %h want %h", inst_addr, BASE + 32'h4); end
  endtask

  task automatic test_redirect_inflight();
    do_reset();
    mem_resp_en = 1'b0; mem_addr_ok = 1'b1; out_ready = 1'b1;
    repeat (4) cycle();
    total++; if (acc_log.size() != 3) begin bad++; $display("FAIL rif_inflight: got %0d want 3", acc_log.size()); end
    mem_addr_ok = 1'b0; redirect_valid = 1'b1; redirect_pc = RDIR;
    cycle();
    redirect_valid = 1'b0;
    total++; if (inst_req !== 1'b1 || inst_addr !== BASE + 32'hC) begin bad++; $display("FAIL rif_pending: got %b@%h want 1@%h", inst_req, inst_addr, BASE + 32'hC); end
    mem_addr_ok = 1'b1; mem_resp_en = 1'b1;
    repeat (14) cycle();
    total++; if (acc_log[3] !== BASE + 32'hC) begin bad++; $display("FAIL rif_stale_acc: got %h want %h", acc_log[3], BASE + 32'hC); end
    total++; if (acc_log[4] !== RDIR) begin bad++; $display("FAIL rif_new_acc: got %h want %h", acc_log[4], RDIR); end
    total++; if (pop_pc[0] !== RDIR) begin bad++; $display("FAIL rif_first_pc: got %h want %h", pop_pc[0], RDIR); end
    total++; if (pop_inst[0] !== memf(RDIR)) begin bad++; $display("FAIL rif_first_inst: got %h want %h", pop_inst[0], memf(RDIR)); end
    total++; if (pop_pc[1] !== RDIR + 32'h4) begin bad++; $display("FAIL rif_second_pc: got %h want %h", pop_pc[1], RDIR + 32'h4); end
  endtask

  task automatic test_redirect_pending();
    do_reset();
    mem_addr_ok = 1'b1; out_ready = 1'b0;
    repeat (8) cycle();
    mem_addr_ok = 1'b0; out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    total++; if (inst_req !== 1'b1 || inst_addr !== BASE + 32'h10) begin bad++; $display("FAIL rp_pending: got %b@%h want 1@%h", inst_req, inst_addr, BASE + 32'h10); end
    redirect_valid = 1'b1; redirect_pc = RDIR;
    cycle();
    redirect_valid = 1'b0;
    total++; if (inst_req !== 1'b1 || inst_addr !== BASE + 32'h10) begin bad++; $display("FAIL rp_held: got %b@%h want 1@%h", inst_req, inst_addr, BASE + 32'h10); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rp_flushed: got %b want 0", out_valid); end
    mem_addr_ok = 1'b1; out_ready = 1'b1;
    pop_pc.delete(); pop_inst.delete();
    repeat (8) cycle();
    total++; if (acc_log[4] !== BASE + 32'h10) begin bad++; $display("FAIL rp_stale_acc: got %h want %h", acc_log[4], BASE + 32'h10); end
    total++; if (acc_log[5] !== RDIR) begin bad++; $display("FAIL rp_new_acc: got %h want %h", acc_log[5], RDIR); end
    total++; if (pop_pc[0] !== RDIR) begin bad++; $display("FAIL rp_first_pc: got %h want %h", pop_pc[0], RDIR); end
    total++; if (pop_inst[0] !== memf(RDIR)) begin bad++; $display("FAIL rp_first_inst: got %h want %h", pop_inst[0], memf(RDIR)); end
  endtask

  task automatic test_redirect_simul();
    do_reset();
    mem_addr_ok = 1'b1; out_ready = 1'b1;
    repeat (4) cycle();
    total++; if (inst_req !== 1'b1 || inst_addr !== BASE + 32'hC) begin bad++; $display("FAIL rs_setup_req: got %b@%h want 1@%h", inst_req, inst_addr, BASE + 32'hC); end
    total++; if (out_valid !== 1'b1 || out_pc !== BASE + 32'h4) begin bad++; $display("FAIL rs_setup_head: got %b@%h want 1@%h", out_valid, out_pc, BASE + 32'h4); end
    redirect_valid = 1'b1; redirect_pc = RDIR;
    cycle();
    redirect_valid = 1'b0;
    repeat (8) cycle();
    total++; if (pop_pc.size() < 4) begin bad++; $display("FAIL rs_pops: got %0d want >=4", pop_pc.size()); end
    total++; if (pop_pc[0] !== BASE || pop_pc[1] !== BASE + 32'h4) begin bad++; $display("FAIL rs_old_pops: got %h,%h want %h,%h", pop_pc[0], pop_pc[1], BASE, BASE + 32'h4); end
    total++; if (pop_pc[2] !== RDIR) begin bad++; $display("FAIL rs_new_pc: got %h want %h", pop_pc[2], RDIR); end
    total++; if (pop_inst[2] !== memf(RDIR)) begin bad++; $display("FAIL rs_new_inst: got %h want %h", pop_inst[2], memf(RDIR)); end
    total++; if (pop_pc[3] !== RDIR + 32'h4) begin bad++; $display("FAIL rs_next_pc: got %h want %h", pop_pc[3], RDIR + 32'h4); end
    total++; if (acc_log[3] !== BASE + 32'hC || acc_log[4] !== RDIR) begin bad++; $display("FAIL rs_acc: got %h,%h want %h,%h", acc_log[3], acc_log[4], BASE + 32'hC, RDIR); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_addr_ok_delay();
    test_redirect_inflight();
    test_redirect_pending();
    test_redirect_simul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
